// File: rtl/maria_bus_pkg.sv
// Shared types and widths for the MARIA bus arbiter slice.
package maria_bus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HALT_REQ = 2'd1,
      DMA      = 2'd2,
      RELEASE  = 2'd3
   } arb_state_t;

   localparam int unsigned ARB_SETTLE_W = 3;
   localparam int unsigned ARB_WD_W     = 12;

endpackage

// File: rtl/maria_bus_arbiter_if.sv
// Handshake bundle between the memory-map/line-timing side and the bus arbiter.
interface maria_bus_arbiter_if;

   logic pclk0;
   logic tia_en;
   logic slow_access;
   logic dma_req;
   logic dma_done;
   logic wsync_req;
   logic line_start;
   logic halt_b;
   logic rdy;
   logic drive_AB;
   logic dma_grant;
   logic dma_timeout_err;

   modport master (
      output pclk0, tia_en, slow_access, dma_req, dma_done, wsync_req, line_start,
      input  halt_b, rdy, drive_AB, dma_grant, dma_timeout_err
   );

   modport slave (
      input  pclk0, tia_en, slow_access, dma_req, dma_done, wsync_req, line_start,
      output halt_b, rdy, drive_AB, dma_grant, dma_timeout_err
   );

endinterface

// File: rtl/dma_watchdog.sv
// DMA ownership timeout: counts cycles spent in DMA and flags a sticky error on expiry.
module dma_watchdog
   import maria_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 4095
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_dma_i,
   output logic expire_c_o,
   output logic err_o
);

   localparam logic [ARB_WD_W-1:0] LIMIT = ARB_WD_W'(TIMEOUT);

   logic [ARB_WD_W-1:0] cnt_q, cnt_d;
   logic                err_q, err_d;

   assign expire_c_o = in_dma_i && (cnt_q == LIMIT);
   assign err_o      = err_q;

   // Counter saturates at the limit and clears whenever DMA is not owned.
   always_comb begin
      cnt_d = '0;
      err_d = err_q | expire_c_o;
      if (in_dma_i) begin
         cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/maria_bus_arbiter.sv
// 7800 bus ownership sequencer between the 6502 and MARIA DMA, with HALT/RDY/WSYNC control.
// Optional DMA watchdog is enabled by defining MARIA_BUS_ARB_WATCHDOG_EN.
module maria_bus_arbiter
   import maria_bus_pkg::*;
#(
   parameter int unsigned HALT_SETTLE = 2
`ifdef MARIA_BUS_ARB_WATCHDOG_EN
   , parameter int unsigned DMA_TIMEOUT = 4095
`endif
) (
   input  logic                sysclock,
   input  logic                reset_b,
   maria_bus_arbiter_if.slave  arb_if
);

   localparam logic [ARB_SETTLE_W-1:0] SETTLE_LIM = ARB_SETTLE_W'(HALT_SETTLE);

   arb_state_t              state_q, state_d;
   logic [ARB_SETTLE_W-1:0] settle_q, settle_d;
   logic                    halt_b_q, halt_b_d;
   logic                    rdy_q, rdy_d;
   logic                    drive_q, drive_d;
   logic                    grant_q, grant_d;
   logic                    wd_expire_c;

   // State and output registers.
   always_ff @(posedge sysclock or negedge reset_b) begin
      if (!reset_b) begin
         state_q  <= IDLE;
         settle_q <= '0;
         halt_b_q <= 1'b1;
         rdy_q    <= 1'b1;
         drive_q  <= 1'b0;
         grant_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         halt_b_q <= halt_b_d;
         rdy_q    <= rdy_d;
         drive_q  <= drive_d;
         grant_q  <= grant_d;
      end
   end

   // Next state; the settle counter only runs inside HALT_REQ, so entry always sees zero.
   always_comb begin
      state_d  = state_q;
      settle_d = '0;
      if (state_q == HALT_REQ) begin
         settle_d = settle_q;
         if (arb_if.pclk0 && !arb_if.slow_access && (settle_q < SETTLE_LIM)) begin
            settle_d = settle_q + 1'b1;
         end
      end
      if (arb_if.tia_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     if (arb_if.dma_req) state_d = HALT_REQ;
            HALT_REQ: begin
               if (!arb_if.dma_req)            state_d = IDLE;
               else if (settle_q == SETTLE_LIM) state_d = DMA;
            end
            DMA:      if (arb_if.dma_done || wd_expire_c) state_d = RELEASE;
            RELEASE:  if (arb_if.pclk0) state_d = arb_if.dma_req ? HALT_REQ : IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   // Registered outputs are decoded from the upcoming state.
   always_comb begin
      halt_b_d = 1'b1;
      drive_d  = 1'b0;
      grant_d  = (state_q == HALT_REQ) && (state_d == DMA);
      rdy_d    = rdy_q;
      case (state_d)
         HALT_REQ, RELEASE: halt_b_d = 1'b0;
         DMA: begin
            halt_b_d = 1'b0;
            drive_d  = 1'b1;
         end
         default: ;
      endcase
      // A WSYNC write beats a coincident line start; the stall waits for the next one.
      if (arb_if.wsync_req)       rdy_d = 1'b0;
      else if (arb_if.line_start) rdy_d = 1'b1;
   end

`ifdef MARIA_BUS_ARB_WATCHDOG_EN
   logic wd_err;

   dma_watchdog #(
      .TIMEOUT (DMA_TIMEOUT)
   ) u_dma_watchdog (
      .clk        (sysclock),
      .rst_n      (reset_b),
      .in_dma_i   (state_q == DMA),
      .expire_c_o (wd_expire_c),
      .err_o      (wd_err)
   );

   assign arb_if.dma_timeout_err = wd_err;
`else
   assign wd_expire_c            = 1'b0;
   assign arb_if.dma_timeout_err = 1'b0;
`endif

   assign arb_if.halt_b    = halt_b_q;
   assign arb_if.rdy       = rdy_q;
   assign arb_if.drive_AB  = drive_q;
   assign arb_if.dma_grant = grant_q;

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// Directed plus randomized bench for maria_bus_arbiter against a behavioural ownership model.
module tb_maria_bus_arbiter;

   localparam int unsigned HS = 2;
   localparam int unsigned TO = 16;
`ifdef MARIA_BUS_ARB_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic sysclock = 1'b0;
   logic reset_b;
   int   n_checks = 0;
   int   n_errors = 0;

   // Behavioural view: is the CPU halted, does MARIA own the bus, are we in turnaround.
   bit m_halted, m_owned, m_turn, m_rdy, m_grant, m_err;
   int m_settle, m_dcyc;

   maria_bus_arbiter_if bus ();

`ifdef MARIA_BUS_ARB_WATCHDOG_EN
   maria_bus_arbiter #(.HALT_SETTLE(HS), .DMA_TIMEOUT(TO)) dut (
      .sysclock (sysclock), .reset_b (reset_b), .arb_if (bus));
`else
   maria_bus_arbiter #(.HALT_SETTLE(HS)) dut (
      .sysclock (sysclock), .reset_b (reset_b), .arb_if (bus));
`endif

   always #5 sysclock = ~sysclock;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_halted = 0; m_owned = 0; m_turn = 0; m_rdy = 1; m_grant = 0; m_err = 0;
      m_settle = 0; m_dcyc = 0;
   endtask

   task automatic model_step();
      bit expire, was_owned;
      expire    = WD_ON && m_owned && (m_dcyc == int'(TO));
      was_owned = m_owned;
      m_grant   = 0;
      if (bus.tia_en) begin
         m_halted = 0; m_owned = 0; m_turn = 0;
      end else if (m_turn) begin
         if (bus.pclk0) begin
            m_turn = 0; m_halted = bus.dma_req; m_settle = 0;
         end
      end else if (m_owned) begin
         if (bus.dma_done || expire) begin
            m_owned = 0; m_turn = 1;
         end
      end else if (m_halted) begin
         if (!bus.dma_req) m_halted = 0;
         else if (m_settle == int'(HS)) begin
            m_owned = 1; m_grant = 1;
         end else if (bus.pclk0 && !bus.slow_access) m_settle++;
      end else if (bus.dma_req) begin
         m_halted = 1; m_settle = 0;
      end
      if (expire) m_err = 1;
      m_dcyc = (was_owned && m_owned) ? m_dcyc + 1 : 0;
      if (bus.wsync_req)       m_rdy = 0;
      else if (bus.line_start) m_rdy = 1;
   endtask

   task automatic check_all();
      chk("halt_b",    bus.halt_b,          !m_halted);
      chk("drive_AB",  bus.drive_AB,        m_owned);
      chk("dma_grant", bus.dma_grant,       m_grant);
      chk("rdy",       bus.rdy,             m_rdy);
      chk("err",       bus.dma_timeout_err, m_err);
   endtask

   task automatic tick();
      @(posedge sysclock);
      model_step();
      #1;
      check_all();
   endtask

   task automatic strobe(input bit slow, input int idle);
      bus.pclk0 = 1; bus.slow_access = slow;
      tick();
      bus.pclk0 = 0; bus.slow_access = 0;
      repeat (idle) tick();
   endtask

   task automatic async_reset();
      #2 reset_b = 0;
      #1;
      model_reset();
      chk("rst_drive", bus.drive_AB, 1'b0);
      chk("rst_halt",  bus.halt_b,   1'b1);
      chk("rst_rdy",   bus.rdy,      1'b1);
      chk("rst_grant", bus.dma_grant, 1'b0);
      chk("rst_err",   bus.dma_timeout_err, 1'b0);
      @(negedge sysclock);
      reset_b = 1;
   endtask

   initial begin
      reset_b = 0;
      bus.pclk0 = 0; bus.tia_en = 0; bus.slow_access = 0; bus.dma_req = 0;
      bus.dma_done = 0; bus.wsync_req = 0; bus.line_start = 0;
      model_reset();
      #12;
      chk("reset_halt",  bus.halt_b,   1'b1);
      chk("reset_rdy",   bus.rdy,      1'b1);
      chk("reset_drive", bus.drive_AB, 1'b0);
      chk("reset_grant", bus.dma_grant, 1'b0);
      chk("reset_err",   bus.dma_timeout_err, 1'b0);
      @(negedge sysclock);
      reset_b = 1;

      // Basic DMA sequence
      bus.dma_req = 1;
      tick();
      chk("basic_halt_low", bus.halt_b, 1'b0);
      strobe(0, 3);
      chk("basic_no_own_1strobe", bus.drive_AB, 1'b0);
      bus.pclk0 = 1; tick(); bus.pclk0 = 0;
      chk("basic_no_own_at_2nd", bus.drive_AB, 1'b0);
      tick();
      chk("basic_own", bus.drive_AB, 1'b1);
      chk("basic_grant", bus.dma_grant, 1'b1);
      tick();
      chk("basic_grant_pulse", bus.dma_grant, 1'b0);
      bus.dma_req = 0;
      tick(); tick();
      chk("basic_req_drop_holds", bus.drive_AB, 1'b1);
      bus.dma_done = 1; tick(); bus.dma_done = 0;
      chk("basic_done_release", bus.drive_AB, 1'b0);
      chk("basic_turn_halt", bus.halt_b, 1'b0);
      tick(); tick();
      chk("basic_turn_hold", bus.halt_b, 1'b0);
      bus.pclk0 = 1; tick(); bus.pclk0 = 0;
      chk("basic_halt_release", bus.halt_b, 1'b1);

      // Slow accesses do not count toward settle
      bus.dma_req = 1;
      tick();
      strobe(1, 3); strobe(1, 3); strobe(0, 3);
      chk("slow_no_own_3", bus.drive_AB, 1'b0);
      bus.pclk0 = 1; tick(); bus.pclk0 = 0;
      chk("slow_no_own_4", bus.drive_AB, 1'b0);
      tick();
      chk("slow_own", bus.drive_AB, 1'b1);
      chk("slow_grant", bus.dma_grant, 1'b1);
      bus.dma_req = 0; bus.dma_done = 1; tick(); bus.dma_done = 0;
      strobe(0, 3);
      chk("slow_idle", bus.halt_b, 1'b1);

      // Abort in HALT_REQ
      bus.dma_req = 1;
      tick();
      strobe(0, 1);
      bus.dma_req = 0;
      tick();
      chk("abort_halt_high", bus.halt_b, 1'b1);
      chk("abort_no_grant", bus.dma_grant, 1'b0);
      repeat (6) tick();
      chk("abort_no_own", bus.drive_AB, 1'b0);

      // WSYNC with coincident line start
      bus.wsync_req = 1; bus.line_start = 1; tick(); bus.wsync_req = 0; bus.line_start = 0;
      chk("wsync_same_cycle", bus.rdy, 1'b0);
      repeat (5) tick();
      chk("wsync_hold", bus.rdy, 1'b0);
      bus.line_start = 1; tick(); bus.line_start = 0;
      chk("wsync_release", bus.rdy, 1'b1);
      bus.wsync_req = 1; tick(); bus.wsync_req = 0;
      chk("wsync_set", bus.rdy, 1'b0);
      bus.line_start = 1; tick(); bus.line_start = 0;
      chk("wsync_next_line", bus.rdy, 1'b1);

      // 2600 mode blocks DMA but not WSYNC
      bus.tia_en = 1; bus.dma_req = 1;
      repeat (3) strobe(0, 3);
      chk("tia_halt_high", bus.halt_b, 1'b1);
      chk("tia_no_own", bus.drive_AB, 1'b0);
      bus.wsync_req = 1; tick(); bus.wsync_req = 0;
      chk("tia_wsync", bus.rdy, 1'b0);
      bus.line_start = 1; tick(); bus.line_start = 0;
      chk("tia_wsync_clear", bus.rdy, 1'b1);
      bus.tia_en = 0;
      tick();
      chk("tia_off_halt", bus.halt_b, 1'b0);
      strobe(0, 3); strobe(0, 3);
      chk("tia_pre_own", bus.drive_AB, 1'b1);
      bus.tia_en = 1; tick();
      chk("tia_force_drive", bus.drive_AB, 1'b0);
      chk("tia_force_halt", bus.halt_b, 1'b1);
      bus.tia_en = 0; bus.dma_req = 0; tick();

      // Asynchronous reset mid-DMA
      bus.dma_req = 1;
      tick();
      strobe(0, 3); strobe(0, 3);
      chk("rst_pre_own", bus.drive_AB, 1'b1);
      bus.wsync_req = 1; tick(); bus.wsync_req = 0;
      chk("rst_pre_rdy", bus.rdy, 1'b0);
      bus.dma_req = 0;
      async_reset();

      // Watchdog (or its absence) on a DMA with no dma_done
      bus.dma_req = 1;
      tick();
      strobe(0, 3);
      bus.pclk0 = 1; tick(); bus.pclk0 = 0;
      tick();
      chk("wd_grant", bus.dma_grant, 1'b1);
      bus.dma_req = 0;
`ifdef MARIA_BUS_ARB_WATCHDOG_EN
      repeat (16) tick();
      chk("wd_still_own", bus.drive_AB, 1'b1);
      chk("wd_no_err_yet", bus.dma_timeout_err, 1'b0);
      tick();
      chk("wd_release", bus.drive_AB, 1'b0);
      chk("wd_err_set", bus.dma_timeout_err, 1'b1);
      strobe(0, 3); strobe(0, 3);
      chk("wd_err_sticky", bus.dma_timeout_err, 1'b1);
      async_reset();
`else
      repeat (40) tick();
      chk("nowd_own", bus.drive_AB, 1'b1);
      chk("nowd_err", bus.dma_timeout_err, 1'b0);
      bus.dma_done = 1; tick(); bus.dma_done = 0;
      chk("nowd_release", bus.drive_AB, 1'b0);
      strobe(0, 3);
`endif

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         bus.pclk0       = ((k % 4) == 0);
         bus.slow_access = (($urandom % 10) < 3);
         if (($urandom % 20) == 0)  bus.dma_req = ~bus.dma_req;
         bus.dma_done    = (($urandom % 25) == 0);
         bus.wsync_req   = (($urandom % 30) == 0);
         bus.line_start  = (($urandom % 40) == 0);
         if (($urandom % 150) == 0) bus.tia_en = ~bus.tia_en;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/maria_bus_arbiter.md
# maria_bus_arbiter

Sequences ownership of the 7800 system bus between the 6502 and MARIA DMA. It also controls the CPU HALT and RDY lines, including the WSYNC stall. The block sits between the MARIA register/memory-map decode and the CPU core. It produces the `drive_AB` ownership flag that the memory map uses to decode chip selects and pick the clock speed.

## Interface
- HALT_SETTLE, default 2: `pclk0` strobes HALT must be held low before MARIA takes the bus (1..7).
- DMA_TIMEOUT, default 4095: `sysclock` cycles of DMA ownership before the watchdog forces release (watchdog builds only).
- sysclock  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- pclk0  in  1  one-`sysclock` strobe marking each CPU bus-cycle boundary
- tia_en  in  1  2600 mode; MARIA DMA disabled
- slow_access  in  1  current CPU cycle is a slow (TIA/RIOT) access
- dma_req  in  1  MARIA requests the bus (level)
- dma_done  in  1  MARIA has finished its DMA burst (one-cycle pulse)
- wsync_req  in  1  WSYNC write strobe from the memory map
- line_start  in  1  start-of-line pulse from line timing
- halt_b  out  1  active-low HALT to the CPU
- rdy  out  1  CPU RDY
- drive_AB  out  1  MARIA owns the address bus
- dma_grant  out  1  one-cycle pulse when MARIA ownership begins
- dma_timeout_err  out  1  sticky watchdog flag (constant 0 when the watchdog is compiled out)

## Operation
- States: IDLE, HALT_REQ, DMA, RELEASE. All outputs are registered.
- IDLE
  - Outputs: halt_b=1, drive_AB=0.
  - Moves to HALT_REQ when dma_req=1 and tia_en=0.
- HALT_REQ
  - halt_b=0. The settle counter is cleared on entry.
  - The counter increments on each `pclk0` where slow_access=0. Strobes with slow_access=1 do not count.
  - When the count reaches HALT_SETTLE, the block moves to DMA and pulses dma_grant.
  - If dma_req drops first, the block returns to IDLE with halt_b=1.
- DMA
  - halt_b=0, drive_AB=1.
  - Moves to RELEASE on dma_done.
  - dma_req going low without dma_done does not end DMA.
- RELEASE
  - drive_AB=0, halt_b stays 0 for a one-strobe bus turnaround.
  - On the next `pclk0` it moves to IDLE. If dma_req=1 at that point, it goes straight to HALT_REQ instead.
- WSYNC
  - wsync_req sets a `wsync_hold` flag. `rdy` = ~wsync_hold.
  - The next line_start strictly after the wsync_req cycle clears the flag.
  - If wsync_req and line_start occur in the same cycle, the flag is set and waits for the following line_start.
- tia_en=1
  - In any state the FSM forces IDLE on the next clock.
  - halt_b=1, drive_AB=0.
  - WSYNC still works.
- Reset (asynchronous, including mid-DMA)
  - State returns to IDLE and the counters clear.
  - halt_b=1, rdy=1, drive_AB=0, dma_grant=0, dma_timeout_err=0.

## Timing
- dma_req to halt_b low: 1 `sysclock`.
- halt_b low to drive_AB=1: HALT_SETTLE qualifying `pclk0` strobes plus 1 `sysclock`.
- dma_done to drive_AB=0: 1 `sysclock`.
- drive_AB=0 to halt_b=1: the next `pclk0` plus 1 `sysclock`.
- wsync_req to rdy=0: 1 `sysclock`.
- line_start to rdy=1: 1 `sysclock`.
- The settle counter is 3 bits and saturates at HALT_SETTLE; it never wraps.

## Configuration
- Macro: `MARIA_BUS_ARB_WATCHDOG_EN`.
- When defined:
  - A 12-bit counter runs in DMA and clears on any other state.
  - When it reaches DMA_TIMEOUT, the FSM moves to RELEASE as if dma_done had arrived.
  - dma_timeout_err is set and stays set until reset.
- When undefined: no counter; dma_timeout_err is tied 0; DMA lasts until dma_done.

## Structure
- Shared package `maria_bus_pkg` holds:
  - the state enum `arb_state_t` {IDLE, HALT_REQ, DMA, RELEASE};
  - the constant `ARB_SETTLE_W`=3.
- One sub-module, `dma_watchdog`: the timeout counter, instantiated only under the macro.

## Test plan
- Basic DMA, HALT_SETTLE=2, `pclk0` every 4 clocks: dma_req at t0 -> halt_b=0 at t1; drive_AB=1 with a dma_grant pulse after the 2nd `pclk0`; dma_done -> drive_AB=0 next clock; halt_b=1 after the next `pclk0`.
- Slow access: slow_access=1 on the first two `pclk0` strobes of HALT_REQ -> drive_AB rises only after the 4th strobe.
- Abort: dma_req drops after 1 strobe in HALT_REQ -> halt_b=1 next clock; no grant pulse.
- WSYNC: wsync_req and line_start in the same cycle -> rdy=0 and stays 0 until the next line_start; rdy=1 one clock after it.
- 2600 mode and reset:
  - tia_en=1 with dma_req=1 -> halt_b stays 1, drive_AB stays 0.
  - reset_b low mid-DMA -> drive_AB=0, halt_b=1 asynchronously.
- Watchdog (macro on, DMA_TIMEOUT=16): no dma_done -> drive_AB falls 17 clocks after grant; dma_timeout_err=1 and stays set until reset.
